// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction/operand byte fetcher. Reads opcodes and operand
//            bytes over a simple req/ack memory bus, folds the 0xCB prefix
//            into a single 16-bit-opcode presentation, maintains the PC and
//            handles redirects that arrive while a bus read is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit (
    input  wire logic        clk,
    input  wire logic        rst_n,

    // memory bus
    output logic [15:0]      mem_addr,
    output logic             mem_rd,
    input  wire logic        mem_ack,
    input  wire logic [7:0]  mem_rdata,

    // control
    input  wire logic        fetch_req,
    input  wire logic        imm_req,
    input  wire logic        pc_load,
    input  wire logic [15:0] pc_load_val,
    input  wire logic        halt,

    // decode side
    output logic [7:0]       o_instr,
    output logic             o_is_instr16,
    output logic             o_instr_valid,
    input  wire logic        i_instr_ready,
    output logic [7:0]       o_imm,
    output logic             o_imm_valid,
    output logic [15:0]      o_pc
);

    localparam logic [7:0] c_cb_prefix = 8'hCB;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_OP_RD  = 3'd1,
        S_CB_RD  = 3'd2,
        S_IMM_RD = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_pc;
    logic [15:0] r_mem_addr;
    logic        r_mem_rd;
    logic [7:0]  r_instr;
    logic        r_is_instr16;
    logic        r_instr_valid;
    logic [7:0]  r_imm;
    logic        r_imm_valid;
    logic        r_pend_valid;
    logic [15:0] r_pend_val;

    logic [15:0] w_pc_nxt;
    logic [15:0] w_mem_addr_nxt;
    logic        w_mem_rd_nxt;
    logic [7:0]  w_instr_nxt;
    logic        w_is_instr16_nxt;
    logic        w_instr_valid_nxt;
    logic [7:0]  w_imm_nxt;
    logic        w_imm_valid_nxt;
    logic        w_pend_valid_nxt;
    logic [15:0] w_pend_val_nxt;

    logic [15:0] w_pc_inc;
    logic        w_redirect;
    logic [15:0] w_redirect_target;
    logic        w_handshake;

    // PC increment wraps 0xFFFF -> 0x0000 through natural 16-bit overflow.
    assign w_pc_inc = r_pc + 16'd1;

    // A redirect seen during a read is either already pending or arriving on
    // the ack edge itself; the newest value always wins.
    assign w_redirect        = r_pend_valid | pc_load;
    assign w_redirect_target = pc_load ? pc_load_val : r_pend_val;

    assign w_handshake = r_instr_valid & i_instr_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-value decode for every registered output.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_rd_nxt      = r_mem_rd;
        w_instr_nxt       = r_instr;
        w_is_instr16_nxt  = r_is_instr16;
        w_instr_valid_nxt = r_instr_valid;
        w_imm_nxt         = r_imm;
        w_imm_valid_nxt   = 1'b0;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_val_nxt    = r_pend_val;

        case (r_state)
            S_IDLE: begin
                // A stale mem_ack is simply not looked at here.
                if (pc_load) begin
                    w_pc_nxt          = pc_load_val;
                    w_instr_valid_nxt = 1'b0;
                end else if (!halt && fetch_req) begin
                    w_mem_addr_nxt = r_pc;
                    w_mem_rd_nxt   = 1'b1;
                    w_state_nxt    = S_OP_RD;
                end else if (!halt && imm_req) begin
                    w_mem_addr_nxt = r_pc;
                    w_mem_rd_nxt   = 1'b1;
                    w_state_nxt    = S_IMM_RD;
                end
            end

            S_OP_RD, S_CB_RD, S_IMM_RD: begin
                if (mem_ack) begin
                    if (w_redirect) begin
                        // Bus read finished but the data is stale: drop it.
                        w_pc_nxt         = w_redirect_target;
                        w_pend_valid_nxt = 1'b0;
                        w_mem_rd_nxt     = 1'b0;
                        w_state_nxt      = S_IDLE;
                    end else if (r_state == S_OP_RD && mem_rdata == c_cb_prefix) begin
                        // Prefix byte is swallowed; chain straight into the suffix read.
                        w_pc_nxt       = w_pc_inc;
                        w_mem_addr_nxt = w_pc_inc;
                        w_mem_rd_nxt   = 1'b1;
                        w_state_nxt    = S_CB_RD;
                    end else if (r_state == S_IMM_RD) begin
                        w_pc_nxt        = w_pc_inc;
                        w_imm_nxt       = mem_rdata;
                        w_imm_valid_nxt = 1'b1;
                        w_mem_rd_nxt    = 1'b0;
                        w_state_nxt     = S_IDLE;
                    end else begin
                        w_pc_nxt          = w_pc_inc;
                        w_instr_nxt       = mem_rdata;
                        w_is_instr16_nxt  = (r_state == S_CB_RD);
                        w_instr_valid_nxt = 1'b1;
                        w_mem_rd_nxt      = 1'b0;
                        w_state_nxt       = S_HOLD;
                    end
                end else if (pc_load) begin
                    w_pend_valid_nxt = 1'b1;
                    w_pend_val_nxt   = pc_load_val;
                end
            end

            S_HOLD: begin
                // Redirect owns the PC; the presented opcode is retired either way.
                if (pc_load) begin
                    w_pc_nxt          = pc_load_val;
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = S_IDLE;
                end else if (w_handshake) begin
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = S_IDLE;
                end
            end

            default: begin
                w_mem_rd_nxt      = 1'b0;
                w_instr_valid_nxt = 1'b0;
                w_pend_valid_nxt  = 1'b0;
                w_state_nxt       = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= 16'h0000;
            r_mem_addr    <= 16'h0000;
            r_mem_rd      <= 1'b0;
            r_instr       <= 8'h00;
            r_is_instr16  <= 1'b0;
            r_instr_valid <= 1'b0;
            r_imm         <= 8'h00;
            r_imm_valid   <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_val    <= 16'h0000;
        end else begin
            r_pc          <= w_pc_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_rd      <= w_mem_rd_nxt;
            r_instr       <= w_instr_nxt;
            r_is_instr16  <= w_is_instr16_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_imm         <= w_imm_nxt;
            r_imm_valid   <= w_imm_valid_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_val    <= w_pend_val_nxt;
        end
    end

    assign mem_addr      = r_mem_addr;
    assign mem_rd        = r_mem_rd;
    assign o_instr       = r_instr;
    assign o_is_instr16  = r_is_instr16;
    assign o_instr_valid = r_instr_valid;
    assign o_imm         = r_imm;
    assign o_imm_valid   = r_imm_valid;
    assign o_pc          = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit with a byte memory
//            responder of programmable ack latency.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        fetch_req;
    logic        imm_req;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        halt;
    logic [7:0]  o_instr;
    logic        o_is_instr16;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [7:0]  o_imm;
    logic        o_imm_valid;
    logic [15:0] o_pc;

    int checks = 0;
    int errors = 0;

    // memory responder state
    logic [7:0]  mem [0:65535];
    int          lat;
    int          cnt;
    int          nreads;
    int          addr_err;
    logic [15:0] rd_addr;
    logic        force_ack;
    int          r0;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .fetch_req    (fetch_req),
        .imm_req      (imm_req),
        .pc_load      (pc_load),
        .pc_load_val  (pc_load_val),
        .halt         (halt),
        .o_instr      (o_instr),
        .o_is_instr16 (o_is_instr16),
        .o_instr_valid(o_instr_valid),
        .i_instr_ready(i_instr_ready),
        .o_imm        (o_imm),
        .o_imm_valid  (o_imm_valid),
        .o_pc         (o_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: acks after mem_rd has been seen high for more than lat cycles.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        cnt       = 0;
        nreads    = 0;
        addr_err  = 0;
        rd_addr   = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (force_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'hEE;
            end else begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    cnt     = 0;
                end
                if (mem_rd) begin
                    cnt++;
                    if (cnt == 1) begin
                        nreads++;
                        rd_addr = mem_addr;
                    end else if (mem_addr !== rd_addr) begin
                        addr_err++;
                    end
                    if (cnt > lat) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem[mem_addr];
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        fetch_req     = 1'b0;
        imm_req       = 1'b0;
        pc_load       = 1'b0;
        pc_load_val   = 16'h0000;
        halt          = 1'b0;
        i_instr_ready = 1'b0;
        force_ack     = 1'b0;
        lat           = 1;
        mem[16'h0000] = 8'h3E;
        mem[16'h0100] = 8'hCB;
        mem[16'h0101] = 8'h37;
        mem[16'hFFFF] = 8'hA5;
        mem[16'h0038] = 8'h77;
        mem[16'h0200] = 8'h12;

        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc",     {16'h0, o_pc}, 32'h0000);
        check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        check("rst_addr",   {16'h0, mem_addr}, 32'h0000);
        check("rst_valid",  {31'h0, o_instr_valid}, 32'h0);
        check("rst_instr",  {24'h0, o_instr}, 32'h00);
        check("rst_is16",   {31'h0, o_is_instr16}, 32'h0);
        check("rst_imm",    {24'h0, o_imm}, 32'h00);
        check("rst_immv",   {31'h0, o_imm_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- plain opcode fetch, minimum latency
        fetch_req = 1'b1;
        tick();                                  // edge N
        check("op_rd",   {31'h0, mem_rd}, 32'h1);
        check("op_addr", {16'h0, mem_addr}, 32'h0000);
        fetch_req = 1'b0;
        tick();                                  // edge N+1
        check("op_early_valid", {31'h0, o_instr_valid}, 32'h0);
        tick();                                  // edge N+2
        check("op_valid", {31'h0, o_instr_valid}, 32'h1);
        check("op_instr", {24'h0, o_instr}, 32'h3E);
        check("op_is16",  {31'h0, o_is_instr16}, 32'h0);
        check("op_pc",    {16'h0, o_pc}, 32'h0001);

        // ---- hold with consumer stalled for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_instr", {24'h0, o_instr}, 32'h3E);
            check("hold_valid", {31'h0, o_instr_valid}, 32'h1);
            check("hold_no_rd", {31'h0, mem_rd}, 32'h0);
        end
        i_instr_ready = 1'b1;
        tick();
        check("hold_accept", {31'h0, o_instr_valid}, 32'h0);
        i_instr_ready = 1'b0;

        // ---- 0xCB-prefixed fetch at 0x0100
        pc_load     = 1'b1;
        pc_load_val = 16'h0100;
        tick();
        pc_load = 1'b0;
        check("cb_load_pc", {16'h0, o_pc}, 32'h0100);
        r0        = nreads;
        fetch_req = 1'b1;
        tick();                                  // N
        check("cb_addr0", {16'h0, mem_addr}, 32'h0100);
        fetch_req = 1'b0;
        tick();                                  // N+1
        tick();                                  // N+2: prefix consumed
        check("cb_rd2",    {31'h0, mem_rd}, 32'h1);
        check("cb_addr1",  {16'h0, mem_addr}, 32'h0101);
        check("cb_noval",  {31'h0, o_instr_valid}, 32'h0);
        check("cb_pc_mid", {16'h0, o_pc}, 32'h0101);
        tick();                                  // N+3
        check("cb_noval2", {31'h0, o_instr_valid}, 32'h0);
        tick();                                  // N+4
        check("cb_valid", {31'h0, o_instr_valid}, 32'h1);
        check("cb_instr", {24'h0, o_instr}, 32'h37);
        check("cb_is16",  {31'h0, o_is_instr16}, 32'h1);
        check("cb_pc",    {16'h0, o_pc}, 32'h0102);
        check("cb_reads", nreads - r0, 32'd2);
        i_instr_ready = 1'b1;
        tick();
        check("cb_accept", {31'h0, o_instr_valid}, 32'h0);
        i_instr_ready = 1'b0;

        // ---- operand read at 0xFFFF with PC wrap
        pc_load     = 1'b1;
        pc_load_val = 16'hFFFF;
        tick();
        pc_load = 1'b0;
        imm_req = 1'b1;
        tick();                                  // N
        check("imm_rd",   {31'h0, mem_rd}, 32'h1);
        check("imm_addr", {16'h0, mem_addr}, 32'hFFFF);
        imm_req = 1'b0;
        tick();
        tick();                                  // N+2
        check("imm_valid", {31'h0, o_imm_valid}, 32'h1);
        check("imm_data",  {24'h0, o_imm}, 32'hA5);
        check("imm_pc",    {16'h0, o_pc}, 32'h0000);
        tick();
        check("imm_pulse",  {31'h0, o_imm_valid}, 32'h0);
        check("imm_no_ins", {31'h0, o_instr_valid}, 32'h0);

        // ---- redirect during a slow opcode read, pending value overwritten
        lat       = 3;
        fetch_req = 1'b1;
        tick();                                  // N
        check("rdr_rd", {31'h0, mem_rd}, 32'h1);
        fetch_req   = 1'b0;
        pc_load     = 1'b1;
        pc_load_val = 16'h0020;
        tick();                                  // N+1
        pc_load_val = 16'h0038;
        tick();                                  // N+2
        pc_load = 1'b0;
        check("rdr_pc_hold", {16'h0, o_pc}, 32'h0000);
        check("rdr_rd_held", {31'h0, mem_rd}, 32'h1);
        tick();                                  // N+3
        check("rdr_noval3", {31'h0, o_instr_valid}, 32'h0);
        check("rdr_addr",   {16'h0, mem_addr}, 32'h0000);
        tick();                                  // N+4: ack consumed
        check("rdr_pc",     {16'h0, o_pc}, 32'h0038);
        check("rdr_rd_off", {31'h0, mem_rd}, 32'h0);
        check("rdr_noval4", {31'h0, o_instr_valid}, 32'h0);
        tick();
        check("rdr_noval5", {31'h0, o_instr_valid}, 32'h0);
        lat       = 1;
        fetch_req = 1'b1;
        tick();
        check("rdr_next_addr", {16'h0, mem_addr}, 32'h0038);
        fetch_req = 1'b0;
        tick();
        tick();
        check("rdr_next_instr", {24'h0, o_instr}, 32'h77);
        check("rdr_next_pc",    {16'h0, o_pc}, 32'h0039);

        // ---- redirect coinciding with HOLD handshake
        pc_load       = 1'b1;
        pc_load_val   = 16'h0200;
        i_instr_ready = 1'b1;
        tick();
        pc_load       = 1'b0;
        i_instr_ready = 1'b0;
        check("hs_ld_valid", {31'h0, o_instr_valid}, 32'h0);
        check("hs_ld_pc",    {16'h0, o_pc}, 32'h0200);
        tick();
        check("hs_ld_idle", {31'h0, mem_rd}, 32'h0);

        // ---- halt blocks IDLE start
        halt      = 1'b1;
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_no_rd", {31'h0, mem_rd}, 32'h0);
        end
        halt = 1'b0;
        tick();
        check("halt_rel_rd",   {31'h0, mem_rd}, 32'h1);
        check("halt_rel_addr", {16'h0, mem_addr}, 32'h0200);
        fetch_req = 1'b0;
        tick();
        tick();
        check("halt_instr", {24'h0, o_instr}, 32'h12);
        check("halt_pc",    {16'h0, o_pc}, 32'h0201);
        i_instr_ready = 1'b1;
        tick();
        i_instr_ready = 1'b0;

        // ---- reset mid-read, then stale ack in IDLE
        fetch_req = 1'b1;
        tick();
        check("mr_rd", {31'h0, mem_rd}, 32'h1);
        fetch_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_rd_drop", {31'h0, mem_rd}, 32'h0);
        check("mr_pc",      {16'h0, o_pc}, 32'h0000);
        check("mr_addr",    {16'h0, mem_addr}, 32'h0000);
        @(negedge clk);
        rst_n     = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        tick();
        tick();
        check("stale_rd",    {31'h0, mem_rd}, 32'h0);
        check("stale_valid", {31'h0, o_instr_valid}, 32'h0);
        check("stale_immv",  {31'h0, o_imm_valid}, 32'h0);
        check("stale_pc",    {16'h0, o_pc}, 32'h0000);

        check("addr_stable", addr_err, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  in  1  core clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset; assertion clears state immediately, deassertion is sampled on clk.
REQ-003 mem_addr  out  16  byte address of the current read.
REQ-004 mem_rd  out  1  read request, held high until mem_ack.
REQ-005 mem_ack  in  1  read completion; mem_rdata is valid in the same cycle; variable latency of at least 1 cycle after mem_rd rises.
REQ-006 mem_rdata  in  8  read data.
REQ-007 fetch_req  in  1  control requests the next opcode; sampled only in IDLE.
REQ-008 imm_req  in  1  control requests one operand byte at PC; sampled only in IDLE; fetch_req wins if both are high.
REQ-009 pc_load  in  1  PC redirect strobe (jump, call, ret, rst, interrupt).
REQ-010 pc_load_val  in  16  redirect target.
REQ-011 halt  in  1  while high, no new request is started from IDLE.
REQ-012 o_instr  out  8  opcode byte presented to decode.
REQ-013 o_is_instr16  out  1  o_instr is the suffix byte of a 0xCB-prefixed instruction.
REQ-014 o_instr_valid  out  1  o_instr and o_is_instr16 are valid.
REQ-015 i_instr_ready  in  1  consumer accepts o_instr in any cycle where o_instr_valid and i_instr_ready are both high.
REQ-016 o_imm  out  8  operand byte.
REQ-017 o_imm_valid  out  1  single-cycle pulse; o_imm is valid.
REQ-018 o_pc  out  16  current PC, the address of the next byte to fetch.

Function
REQ-019 The state machine SHALL have four states: IDLE, OP_RD, CB_RD, IMM_RD, plus an output-hold condition HOLD.
REQ-020 IDLE: with halt low and fetch_req high, the block SHALL drive mem_addr=o_pc and mem_rd=1 and go to OP_RD. With halt low, fetch_req low and imm_req high, it SHALL go to IMM_RD. Otherwise it SHALL stay in IDLE.
REQ-021 mem_rd SHALL be high in the *_RD states only, and mem_addr SHALL stay stable while mem_rd is high.
REQ-022 OP_RD on mem_ack: o_pc increments by 1, wrapping 0xFFFF to 0x0000.
  - If mem_rdata is 0xCB, the block goes to CB_RD and issues a new read at the incremented PC; the prefix byte is never presented.
  - Otherwise o_instr=mem_rdata, o_is_instr16=0, o_instr_valid=1, and the block enters HOLD.
REQ-023 CB_RD on mem_ack: o_pc increments by 1, o_instr=mem_rdata, o_is_instr16=1, o_instr_valid=1, HOLD.
REQ-024 HOLD: o_instr, o_is_instr16 and o_instr_valid SHALL remain stable until the handshake completes, then o_instr_valid clears and the block returns to IDLE on the next cycle.
REQ-025 IMM_RD on mem_ack: o_imm=mem_rdata, o_imm_valid=1 for exactly 1 cycle, o_pc increments by 1 with wrap, return to IDLE.
REQ-026 Minimum latency: fetch_req at edge N SHALL give o_instr_valid at edge N+2 when mem_ack arrives 1 cycle after mem_rd.
REQ-027 pc_load in IDLE or HOLD: the block SHALL set o_pc=pc_load_val on the next edge, clear o_instr_valid, and go to IDLE.
REQ-028 pc_load in a *_RD state:
  - The block SHALL latch pc_load_val as a pending redirect.
  - The bus transaction SHALL complete.
  - On mem_ack, the data SHALL be discarded with no valid and no increment, o_pc SHALL take the pending value, and the block SHALL return to IDLE.
  - A later pc_load before the ack SHALL overwrite the pending value.
REQ-029 pc_load on the same edge as a HOLD handshake SHALL take priority for o_pc; the handshake still completes.
REQ-030 halt rising SHALL NOT abort an in-flight read or a HOLD; it blocks only IDLE transitions.

Reset
REQ-031 On rst_n low the block SHALL set:
  - state=IDLE
  - o_pc=0x0000
  - mem_rd=0, mem_addr=0x0000
  - o_instr=0x00, o_is_instr16=0, o_instr_valid=0
  - o_imm=0x00, o_imm_valid=0
  - pending redirect cleared.
REQ-032 Reset asserted mid-read SHALL drop mem_rd immediately, and a stale mem_ack after reset SHALL be ignored in IDLE.

Verification
REQ-033 Reset, then fetch_req with memory[0x0000]=0x3E and 1-cycle ack -> o_instr=0x3E, o_is_instr16=0, valid at edge 2, o_pc=0x0001.
REQ-034 memory[0x0100..0x0101]=0xCB,0x37 with PC=0x0100 -> two bus reads, single presentation o_instr=0x37 with o_is_instr16=1, o_pc=0x0102.
REQ-035 o_pc=0xFFFF, imm_req, memory[0xFFFF]=0xA5 -> o_imm=0xA5 one-cycle pulse, o_pc=0x0000.
REQ-036 pc_load=1, pc_load_val=0x0038 during OP_RD with 3-cycle ack latency -> no o_instr_valid, o_pc=0x0038 after ack, next fetch reads address 0x0038.
REQ-037 i_instr_ready held low 5 cycles in HOLD -> o_instr stable throughout, no mem_rd, accepted on the first ready cycle.
REQ-038 halt=1 with fetch_req=1 in IDLE -> mem_rd stays 0; halt deasserted -> read starts the next cycle.
